// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared types and constants for the I2C clock generator and its helpers.
//   sclState_e    : controller state (IDLE, RUN, STRETCH)
//   PH_*          : the four quarter-periods of one SCL period
//   STRETCH_GUARD : first counter value in phase 2 at which a low SCL counts as a stretch
//   phaseDrivesLow / phaseDataClk : per-phase pad and data-clock decode
package i2c_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      STRETCH = 2'd2
   } sclState_e;

   localparam logic [1:0] PH_LOW0  = 2'd0;
   localparam logic [1:0] PH_LOW1  = 2'd1;
   localparam logic [1:0] PH_HIGH0 = 2'd2;
   localparam logic [1:0] PH_HIGH1 = 2'd3;

   // The synchroniser adds two cycles and the bus needs at least one more to rise,
   // so a low reading earlier than this in phase 2 is still our own low phase.
   localparam int STRETCH_GUARD = 3;

   // SCL is pulled low for the whole first half of the period.
   function automatic logic phaseDrivesLow(input logic [1:0] ph);
      return (ph == PH_LOW0) || (ph == PH_LOW1);
   endfunction

   // The data clock leads SCL by one quarter, so it is high in phases 1 and 2.
   function automatic logic phaseDataClk(input logic [1:0] ph);
      return (ph == PH_LOW1) || (ph == PH_HIGH0);
   endfunction

endpackage

// File: rtl/i2c_sync2.sv
// i2c_sync2
// Two-flop synchroniser for an open-drain I2C line. Both flops reset to 1 because
// an idle, released bus reads high. Usable for SCL or SDA.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   async_i : raw pad input
//   sync_o  : synchronised copy, two cycles late
module i2c_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   // Plain two-stage shift; the first stage may go metastable, the second is used.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen
// Generates the I2C SCL waveform and a data clock one quarter ahead of it, with
// a runtime quarter-period, slave clock-stretch detection, a stretch timeout and
// a graceful stop at the end of the current period.
//   clk, rst     : clock and asynchronous active-high reset
//   ena          : run request (level)
//   div_q        : quarter-period in clk cycles, latched when a run starts
//   stretch_en   : honour slave clock stretching
//   scl_in       : raw SCL pad input
//   scl_oe       : 1 pulls SCL low, 0 releases it
//   data_clk     : data-phase clock (high in phases 1 and 2)
//   phase        : current quarter 0..3
//   switch_range : high during phase 2 (SCL high window)
//   tick_rise    : pulse on entry to phase 2
//   tick_fall    : pulse on the phase 3 to phase 0 wrap
//   stretching   : high while a slave holds SCL low
//   timeout      : sticky stretch-timeout flag
//   busy         : controller not idle
module i2c_scl_gen
   import i2c_pkg::*;
#(
   parameter int DIV_W     = 16,
   parameter int TO_W      = 20,
   parameter int TO_CYCLES = 500000,
   parameter int MIN_DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [DIV_W-1:0] div_q,
   input  logic             stretch_en,
   input  logic             scl_in,
   output logic             scl_oe,
   output logic             data_clk,
   output logic [1:0]       phase,
   output logic             switch_range,
   output logic             tick_rise,
   output logic             tick_fall,
   output logic             stretching,
   output logic             timeout,
   output logic             busy
);

   localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
   localparam logic [DIV_W-1:0] GUARD_V   = DIV_W'(STRETCH_GUARD);
   localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);

   sclState_e        state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] divLatch_q, divLatch_d;
   logic [1:0]       phase_q, phase_d;
   logic [TO_W-1:0]  toCnt_q, toCnt_d;
   logic             timeout_q, timeout_d;

   logic sclOe_q, sclOe_d;
   logic dataClk_q, dataClk_d;
   logic switchRange_q, switchRange_d;
   logic tickRise_q, tickRise_d;
   logic tickFall_q, tickFall_d;
   logic stretching_q, stretching_d;
   logic busy_q, busy_d;

   logic sclSync;
   logic stretchArmed;
   logic [DIV_W-1:0] divClamped;

   i2c_sync2 u_sclSync (
      .clk     (clk),
      .rst     (rst),
      .async_i (scl_in),
      .sync_o  (sclSync)
   );

   // Too-short quarter-periods would let the stretch check fire on our own low phase.
   assign divClamped = (div_q < MIN_DIV_V) ? MIN_DIV_V : div_q;

   // Stretch detection only looks at the SCL high window, after the guard.
   assign stretchArmed = (phase_q == PH_HIGH0) && (cnt_q >= GUARD_V) && stretch_en;

   // State register, counters and the registered copies of every output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         divLatch_q    <= MIN_DIV_V;
         phase_q       <= PH_LOW0;
         toCnt_q       <= '0;
         timeout_q     <= 1'b0;
         sclOe_q       <= 1'b0;
         dataClk_q     <= 1'b0;
         switchRange_q <= 1'b0;
         tickRise_q    <= 1'b0;
         tickFall_q    <= 1'b0;
         stretching_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         divLatch_q    <= divLatch_d;
         phase_q       <= phase_d;
         toCnt_q       <= toCnt_d;
         timeout_q     <= timeout_d;
         sclOe_q       <= sclOe_d;
         dataClk_q     <= dataClk_d;
         switchRange_q <= switchRange_d;
         tickRise_q    <= tickRise_d;
         tickFall_q    <= tickFall_d;
         stretching_q  <= stretching_d;
         busy_q        <= busy_d;
      end
   end

   // Next-state logic. A stretch freezes the counter and phase in place so the
   // period resumes exactly where it stopped once the slave lets go. Dropping
   // ena only takes effect at the end of phase 3, so a period is never cut short.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      divLatch_d = divLatch_q;
      phase_d    = phase_q;
      toCnt_d    = toCnt_q;
      timeout_d  = timeout_q;

      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            phase_d = PH_LOW0;
            toCnt_d = '0;
            if (ena && !timeout_q) begin
               state_d    = RUN;
               divLatch_d = divClamped;
            end else if (!ena) begin
               timeout_d = 1'b0;
            end
         end

         RUN: begin
            if (stretchArmed && !sclSync) begin
               state_d = STRETCH;
               toCnt_d = '0;
            end else if (cnt_q == divLatch_q - DIV_ONE) begin
               cnt_d = '0;
               if (phase_q == PH_HIGH1) begin
                  phase_d = PH_LOW0;
                  if (!ena) begin
                     state_d = IDLE;
                  end
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + DIV_ONE;
            end
         end

         STRETCH: begin
            if (sclSync) begin
               state_d = RUN;
            end else if (toCnt_q == TO_LAST) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
               cnt_d     = '0;
               phase_d   = PH_LOW0;
            end else begin
               toCnt_d = toCnt_q + TO_ONE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = PH_LOW0;
         end
      endcase
   end

   // Output decode from the next state, so the registered outputs line up with
   // the state registers in the same cycle. Ticks compare old and new phase so
   // a return from STRETCH (phase already 2) does not fire tick_rise again.
   always_comb begin
      busy_d        = (state_d != IDLE);
      sclOe_d       = busy_d && phaseDrivesLow(phase_d);
      dataClk_d     = busy_d && phaseDataClk(phase_d);
      switchRange_d = busy_d && (phase_d == PH_HIGH0);
      tickRise_d    = (state_d == RUN) && (phase_d == PH_HIGH0) && (phase_q != PH_HIGH0);
      tickFall_d    = (state_q == RUN) && (state_d == RUN) &&
                      (phase_q == PH_HIGH1) && (phase_d == PH_LOW0);
      stretching_d  = (state_d == STRETCH);
   end

   assign scl_oe       = sclOe_q;
   assign data_clk     = dataClk_q;
   assign phase        = phase_q;
   assign switch_range = switchRange_q;
   assign tick_rise    = tickRise_q;
   assign tick_fall    = tickFall_q;
   assign stretching   = stretching_q;
   assign timeout      = timeout_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb_i2c_scl_gen
// Drives i2c_scl_gen through directed scenarios and random segments. The pad is
// modelled as open drain: SCL reads low when the generator or the "slave" pulls it.
// The reference model tracks a single position within the SCL period and derives
// every expected output from it arithmetically.
module tb_i2c_scl_gen;

   localparam int DIV_W     = 16;
   localparam int TO_W      = 20;
   localparam int TO_CYCLES = 100;
   localparam int MIN_DIV   = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             ena = 1'b0;
   logic             stretchEn = 1'b0;
   logic             sclIn = 1'b1;
   logic             holdLow = 1'b0;
   logic [DIV_W-1:0] divIn = 16'd5;

   logic       sclOe, dataClk, switchRange, tickRise, tickFall, stretching, timeout, busy;
   logic [1:0] phase;

   int checks = 0;
   int failures = 0;

   bit mRun, mStretch, mTimeout, mFall;
   int mPos, mDiv, mTo;
   bit sclHist [2];

   int expPeriod = 0;
   int cycleIdx = 0;
   int lastFall = -1;

   always #5 clock = ~clock;

   i2c_scl_gen #(
      .DIV_W     (DIV_W),
      .TO_W      (TO_W),
      .TO_CYCLES (TO_CYCLES),
      .MIN_DIV   (MIN_DIV)
   ) dut (
      .clk          (clock),
      .rst          (reset),
      .ena          (ena),
      .div_q        (divIn),
      .stretch_en   (stretchEn),
      .scl_in       (sclIn),
      .scl_oe       (sclOe),
      .data_clk     (dataClk),
      .phase        (phase),
      .switch_range (switchRange),
      .tick_rise    (tickRise),
      .tick_fall    (tickFall),
      .stretching   (stretching),
      .timeout      (timeout),
      .busy         (busy)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic int modelPhase();
      return mRun ? (mPos / mDiv) : 0;
   endfunction

   task automatic modelReset();
      mRun       = 1'b0;
      mStretch   = 1'b0;
      mTimeout   = 1'b0;
      mFall      = 1'b0;
      mPos       = 0;
      mDiv       = MIN_DIV;
      mTo        = 0;
      sclHist[0] = 1'b1;
      sclHist[1] = 1'b1;
      lastFall   = -1;
   endtask

   // One clock of the behavioural model. The controller sees SCL as it was two
   // cycles ago; a period is 4*div positions and a stretch freezes the position.
   task automatic modelStep();
      bit seen;
      seen  = sclHist[1];
      mFall = 1'b0;
      if (!mRun) begin
         if (ena && !mTimeout) begin
            mRun = 1'b1;
            mPos = 0;
            mDiv = (divIn < MIN_DIV) ? MIN_DIV : int'(divIn);
         end else if (!ena) begin
            mTimeout = 1'b0;
         end
      end else if (mStretch) begin
         if (seen) begin
            mStretch = 1'b0;
         end else if (mTo == TO_CYCLES - 1) begin
            mTimeout = 1'b1;
            mStretch = 1'b0;
            mRun     = 1'b0;
         end else begin
            mTo++;
         end
      end else if ((mPos / mDiv == 2) && (mPos % mDiv >= 3) && stretchEn && !seen) begin
         mStretch = 1'b1;
         mTo      = 0;
      end else begin
         mPos++;
         if (mPos == 4 * mDiv) begin
            mPos = 0;
            if (ena) mFall = 1'b1;
            else     mRun  = 1'b0;
         end
      end
      sclHist[1] = sclHist[0];
      sclHist[0] = sclIn;
   endtask

   task automatic checkAll();
      int ph;
      ph = modelPhase();
      checkOutput("busy",        busy,        mRun);
      checkOutput("phase",       phase,       ph);
      checkOutput("sclOe",       sclOe,       mRun && (ph < 2));
      checkOutput("dataClk",     dataClk,     mRun && (ph == 1 || ph == 2));
      checkOutput("switchRange", switchRange, mRun && (ph == 2));
      checkOutput("stretching",  stretching,  mStretch);
      checkOutput("tickRise",    tickRise,    mRun && !mStretch && (mPos == 2 * mDiv));
      checkOutput("tickFall",    tickFall,    mFall);
      checkOutput("timeout",     timeout,     mTimeout);
   endtask

   // Runs n clocks: drive the pad, step the model on the edge, compare on the
   // falling edge, and measure the spacing of tick_fall pulses when requested.
   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         sclIn = !((mRun && (modelPhase() < 2)) || holdLow);
         @(posedge clock);
         if (!reset) modelStep();
         @(negedge clock);
         cycleIdx++;
         checkAll();
         if (!mRun) lastFall = -1;
         if (tickFall === 1'b1) begin
            if (expPeriod != 0 && lastFall >= 0) checkOutput("period", cycleIdx - lastFall, expPeriod);
            lastFall = cycleIdx;
         end
      end
   endtask

   task automatic applyStimulus(input logic e, input logic se, input int d, input logic hl, input int n);
      ena       = e;
      stretchEn = se;
      divIn     = DIV_W'(d);
      holdLow   = hl;
      runCycles(n);
   endtask

   // Waits (bounded) until the model has just entered the given phase.
   task automatic waitPhase(input int ph);
      int budget;
      budget = 4000;
      while (!(mRun && !mStretch && mPos == ph * mDiv) && budget > 0) begin
         runCycles(1);
         budget--;
      end
      checkOutput("waitPhase", phase, ph);
   endtask

   // Asserts reset between clock edges and checks that outputs clear without a clock.
   task automatic applyReset();
      #2 reset = 1'b1;
      #1;
      checkOutput("rstSclOe",      sclOe,       0);
      checkOutput("rstDataClk",    dataClk,     0);
      checkOutput("rstPhase",      phase,       0);
      checkOutput("rstSwitch",     switchRange, 0);
      checkOutput("rstTickRise",   tickRise,    0);
      checkOutput("rstTickFall",   tickFall,    0);
      checkOutput("rstStretching", stretching,  0);
      checkOutput("rstTimeout",    timeout,     0);
      checkOutput("rstBusy",       busy,        0);
      modelReset();
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got %0d cycles", cycleIdx);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      modelReset();
      #1 reset = 1'b1;
      #2;
      checkOutput("initBusy",    busy,    0);
      checkOutput("initSclOe",   sclOe,   0);
      checkOutput("initTimeout", timeout, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Nominal run; a div change while busy must not alter the period.
      expPeriod = 20;
      applyStimulus(1, 1, 5, 0, 30);
      applyStimulus(1, 1, 9, 0, 70);
      applyStimulus(0, 1, 9, 0, 25);
      checkOutput("stopBusy", busy, 0);

      // Quarter-period below the minimum is clamped.
      expPeriod = 16;
      applyStimulus(1, 1, 2, 0, 70);
      applyStimulus(0, 1, 2, 0, 20);

      // Slave holds SCL low for 30 cycles from the start of phase 2.
      expPeriod = 0;
      applyStimulus(1, 1, 8, 0, 1);
      waitPhase(2);
      holdLow = 1'b1;
      runCycles(30);
      holdLow = 1'b0;
      runCycles(60);

      // Stuck SCL: timeout, lockout while ena stays high, restart after ena drops.
      waitPhase(2);
      holdLow = 1'b1;
      runCycles(130);
      checkOutput("timeoutSet", timeout, 1);
      checkOutput("timeoutOe",  sclOe,   0);
      holdLow = 1'b0;
      runCycles(20);
      checkOutput("lockoutBusy", busy, 0);
      applyStimulus(0, 1, 8, 0, 2);
      applyStimulus(1, 1, 8, 0, 10);
      checkOutput("restartBusy", busy, 1);

      // Graceful stop requested in phase 1.
      waitPhase(1);
      runCycles(2);
      ena = 1'b0;
      runCycles(4 * 8 + 5);
      checkOutput("gracefulIdle", busy, 0);

      // Stretching disabled: a low SCL has no effect on the period.
      expPeriod = 32;
      applyStimulus(1, 0, 8, 1, 100);
      holdLow   = 1'b0;
      stretchEn = 1'b1;

      // Reset in phase 2, then an exact first period.
      expPeriod = 0;
      waitPhase(2);
      runCycles(1);
      applyReset();
      expPeriod = 32;
      runCycles(80);

      // Reset during a stretch.
      expPeriod = 0;
      waitPhase(2);
      holdLow = 1'b1;
      runCycles(10);
      checkOutput("midStretch", stretching, 1);
      applyReset();
      holdLow = 1'b0;
      runCycles(60);

      // Largest quarter-period is accepted; leave via reset.
      applyStimulus(0, 1, 8, 0, 40);
      applyStimulus(1, 1, (1 << DIV_W) - 1, 0, 200);
      checkOutput("maxDivPhase", phase, 0);
      applyReset();

      // Random segments.
      for (int seg = 0; seg < 60; seg++) begin
         applyStimulus($urandom_range(5, 0) != 0, $urandom_range(3, 0) != 0,
                       $urandom_range(10, 0), $urandom_range(3, 0) == 0,
                       $urandom_range(60, 5));
         if ($urandom_range(15, 0) == 0) applyReset();
      end
      applyStimulus(0, 1, 5, 0, 60);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_scl_gen.md
Name: i2c_scl_gen

Overview:
Parametrised I2C SCL/data-clock generator with clock-stretch support.
- Successor to the fixed-divider stretcher. Quarter-period length is a runtime input, and stretch is detected on the real synchronised SCL line.
- Adds a stretch timeout, graceful enable/disable and phase-edge strobes.
- Sits between the I2C master byte FSM (consumes data_clk, phase and strobes) and the open-drain SCL pad (scl_oe, scl_in).

Parameters:
DIV_W, 16, width of quarter-period divider input and internal counter
TO_W, 20, width of stretch-timeout counter
TO_CYCLES, 500000, stretch cycles before timeout is declared (must fit in TO_W)
MIN_DIV, 4, lower clamp on quarter-period; covers synchroniser latency plus guard

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ena  in  1  run request; level-sensitive
div_q  in  DIV_W  quarter-period length in clk cycles; latched on IDLE->RUN
stretch_en  in  1  1 = honour slave clock stretching
scl_in  in  1  raw SCL pad input (asynchronous)
scl_oe  out  1  1 = drive SCL low; 0 = release (pulled high)
data_clk  out  1  data-phase clock, 90 degrees ahead of SCL
phase  out  2  current quarter: 0..3
switch_range  out  1  1 while phase==2 (SCL high window)
tick_rise  out  1  one-cycle pulse on entry to phase 2
tick_fall  out  1  one-cycle pulse on entry to phase 0 from phase 3
stretching  out  1  1 while in STRETCH
timeout  out  1  sticky; set on stretch timeout, cleared only in IDLE with ena=0, or by rst
busy  out  1  1 when state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, phase=0, to_cnt=0.
  - scl_oe=0, data_clk=0, switch_range=0, tick_rise=0, tick_fall=0, stretching=0, timeout=0, busy=0.
  - Synchroniser flops reset to 1.
  - Reset mid-operation aborts immediately; SCL is released.
- Outputs: all registered; no combinational input-to-output paths.
- scl_in passes through a 2-flop synchroniser (scl_s), giving 2 cycles of latency.
- Divider latch: div_l = max(div_q, MIN_DIV), captured on IDLE->RUN. Changes to div_q while busy are ignored.
- State IDLE:
  - scl_oe=0, data_clk=0, phase=0.
  - If ena=1 and timeout=0: go to RUN with cnt=0, phase=0, busy=1 on the next cycle.
- State RUN:
  - cnt increments each cycle.
  - At cnt==div_l-1: cnt wraps to 0 and phase advances.
  - Phase 3 end with ena=1 goes to phase 0 and pulses tick_fall. With ena=0 it goes to IDLE with no tick_fall (graceful stop; the period always completes).
- Phase decode:
  - phase 0: scl_oe=1, data_clk=0
  - phase 1: scl_oe=1, data_clk=1
  - phase 2: scl_oe=0, data_clk=1
  - phase 3: scl_oe=0, data_clk=0
- switch_range=1 exactly when phase==2.
- tick_rise pulses in the first cycle with phase==2.
- Stretch detect:
  - Applies in RUN, phase 2, cnt>=3 (guard covers the 2-cycle sync delay plus rise time), when stretch_en=1 and scl_s==0.
  - Effect: go to STRETCH, freeze cnt/phase, clear to_cnt.
  - Detection is not armed in other phases, or when stretch_en=0.
- State STRETCH:
  - stretching=1; outputs held at phase-2 values; to_cnt increments.
  - scl_s==1: return to RUN; cnt resumes from its frozen value on the next cycle.
  - to_cnt==TO_CYCLES-1 before release: set timeout=1, go to IDLE, release SCL.
  - Release and timeout in the same cycle: release wins.
  - ena=0 during STRETCH does not abort; stop happens at the next phase-3 end.
- Timeout lockout: with timeout=1, IDLE refuses to start. timeout clears in IDLE when ena=0.
- Width: cnt is DIV_W bits. div_q=0..MIN_DIV-1 behaves as MIN_DIV. div_q = 2^DIV_W-1 is legal.

Decomposition:
- Package i2c_pkg:
  - state enum {IDLE, RUN, STRETCH}
  - phase constants PH_LOW0=0, PH_LOW1=1, PH_HIGH0=2, PH_HIGH1=3
  - STRETCH_GUARD=3
- Sub-module i2c_sync2: 2-flop synchroniser with async reset-to-1, reusable for SDA.
- Main FSM/counter stays in i2c_scl_gen.

Test Plan:
- div_q=5, ena=1, scl_in follows ~scl_oe, stretch_en=1:
  - SCL period is 20 clk, data_clk high in cycles 5-14 of each period.
  - tick_rise at cycle 10, tick_fall every 20 cycles; never stretching.
- div_q=2:
  - Clamped; period is 16 clk (MIN_DIV=4).
- Stretch: hold scl_in=0 for 30 cycles after phase 2 starts:
  - stretching=1 from phase-2 cnt 3.
  - Phase 2 lasts 5+30-3 cycles (±2 sync latency, verify exact via model).
  - RUN resumes with no phase skipped.
- Timeout: TO_CYCLES=100, scl_in stuck 0 in phase 2:
  - timeout=1 after 100 STRETCH cycles, scl_oe=0, state IDLE.
  - ena held 1 does not restart; ena=0 then 1 does restart.
- ena dropped mid phase 1:
  - Period completes through phase 3, then IDLE. No tick_fall, busy falls.
  - stretch_en=0 with scl_in=0: no stretch, period stays 4*div_l.
- rst asserted mid phase 2 and mid STRETCH:
  - All outputs reach reset values asynchronously, timeout=0.
  - First post-reset period is exact.
